// File: rtl/npu_core_if.sv
// Host-side bus of the NPU core: memory write data, packed control word,
// and the registered partial-sum read data.
interface npu_core_if #(
  parameter int bw      = 8,
  parameter int pr      = 8,
  parameter int col     = 8,
  parameter int bw_psum = 2*bw+4
);
  logic [pr*bw-1:0]       mem_in;
  logic [16:0]            inst;
  logic [col*bw_psum-1:0] out;

  modport master (output mem_in, inst, input out);
  modport slave  (input mem_in, inst, output out);
endinterface

// File: rtl/npu_core.sv
// Q.K attention core: Q/K/P memories, K register bank, col parallel dot-product
// units feeding a 16-deep first-word-fall-through output FIFO.
module npu_core #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int pr      = 8,
  parameter int col     = 8
) (
  input logic       clk,
  input logic       reset,
  npu_core_if.slave io
);
  localparam int unsigned RW = pr*bw;
  localparam int unsigned OW = col*bw_psum;
  localparam int unsigned KW = (col > 1) ? $clog2(col) : 1;

  logic       ofifo_rd, execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr;
  logic [3:0] qk_add, p_add;

  assign ofifo_rd = io.inst[16];
  assign qk_add   = io.inst[15:12];
  assign p_add    = io.inst[11:8];
  assign execute  = io.inst[7];
  assign load     = io.inst[6];
  assign qmem_rd  = io.inst[5];
  assign qmem_wr  = io.inst[4];
  assign kmem_rd  = io.inst[3];
  assign kmem_wr  = io.inst[2];
  assign pmem_rd  = io.inst[1];
  assign pmem_wr  = io.inst[0];

  logic [RW-1:0] qmem [16];
  logic [RW-1:0] kmem [16];
  logic [OW-1:0] pmem [16];
  logic [OW-1:0] fifo [16];

  logic [RW-1:0] qmem_q, kmem_q;
  logic [OW-1:0] out_q;
  logic [RW-1:0] kreg [col];
  logic [KW-1:0] kcnt;
  logic          kvalid, qvalid;

  logic [3:0]    wptr, rptr;
  logic [4:0]    cnt;
  logic          full, empty, push, pop;
  logic [OW-1:0] head, dot;

  assign full  = (cnt == 5'd16);
  assign empty = (cnt == 5'd0);
  assign push  = qvalid && !full;
  assign pop   = ofifo_rd && !empty;
  assign head  = empty ? '0 : fifo[rptr];
  assign io.out = out_q;

  // Storage arrays carry no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (qmem_wr) qmem[qk_add] <= io.mem_in;
    if (kmem_wr) kmem[qk_add] <= io.mem_in;
    if (pmem_wr) pmem[p_add]  <= head;
    if (push)    fifo[wptr]   <= dot;
  end

  // A read coinciding with a write on the same memory leaves the output register untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qmem_q <= '0;
      kmem_q <= '0;
      out_q  <= '0;
      kvalid <= 1'b0;
      qvalid <= 1'b0;
    end else begin
      if (qmem_rd && !qmem_wr) qmem_q <= qmem[qk_add];
      if (kmem_rd && !kmem_wr) kmem_q <= kmem[qk_add];
      if (pmem_rd && !pmem_wr) out_q  <= pmem[p_add];
      kvalid <= kmem_rd;
      qvalid <= execute && qmem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kcnt <= '0;
      for (int unsigned c = 0; c < col; c++) kreg[c] <= '0;
    end else if (!load) begin
      kcnt <= '0;
    end else if (kvalid) begin
      kreg[kcnt] <= kmem_q;
      kcnt       <= (kcnt == KW'(col-1)) ? '0 : kcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  logic signed [2*bw-1:0]  prod;
  logic signed [bw_psum-1:0] acc;

  // Summing in bw_psum bits wraps identically to truncating a full-precision sum.
  always_comb begin
    dot  = '0;
    prod = '0;
    acc  = '0;
    for (int unsigned c = 0; c < col; c++) begin
      acc = '0;
      for (int unsigned k = 0; k < pr; k++) begin
        prod = $signed(qmem_q[k*bw +: bw]) * $signed(kreg[c][k*bw +: bw]);
        acc  = acc + bw_psum'(prod);
      end
      dot[(col-1-c)*bw_psum +: bw_psum] = acc;
    end
  end
endmodule

// File: tb/tb_npu_core.sv
// Randomized self-checking bench for npu_core against an arithmetic model
// of the memories, K register bank and output FIFO.
module tb_npu_core;
  localparam int BW  = 8;
  localparam int PR  = 8;
  localparam int COL = 8;
  localparam int BP  = 20;
  localparam int OW  = COL*BP;
  localparam int RW  = PR*BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npu_core_if #(.bw(BW), .pr(PR), .col(COL), .bw_psum(BP)) bus ();
  npu_core #(.bw(BW), .bw_psum(BP), .pr(PR), .col(COL)) dut (
    .clk(clk), .reset(reset), .io(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int qm [16][PR];
  int km [16][PR];
  int kr [COL][PR];
  logic [OW-1:0] fifo_m [$];
  logic [OW-1:0] pm [16];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input bit ofr, input int qka, input int pa, input bit ex,
                                     input bit ld, input bit qrd, input bit qwr, input bit krd,
                                     input bit kwr, input bit prd, input bit pwr);
    return {ofr, 4'(qka), 4'(pa), ex, ld, qrd, qwr, krd, kwr, prd, pwr};
  endfunction

  function automatic logic [RW-1:0] row_bits(input int e [PR]);
    logic [RW-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < PR; j++) begin
      v = e[j];
      r[j*BW +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  // Expected OFIFO entry for Q row qa against the currently loaded K rows.
  function automatic logic [OW-1:0] dot_row(input int qa);
    logic [OW-1:0] r;
    int s;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int k = 0; k < PR; k++) s += qm[qa][k] * kr[c][k];
      r[(COL-1-c)*BP +: BP] = s[BP-1:0];
    end
    return r;
  endfunction

  function automatic void m_push(input logic [OW-1:0] x);
    if (fifo_m.size() < 16) fifo_m.push_back(x);
  endfunction

  function automatic logic [OW-1:0] m_pop();
    if (fifo_m.size() == 0) return '0;
    return fifo_m.pop_front();
  endfunction

  task automatic step(input logic [16:0] i, input logic [RW-1:0] d);
    bus.inst   = i;
    bus.mem_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step('0, '0);
  endtask

  task automatic drain_and_read(input int n, input int base);
    for (int t = 0; t < n; t++) begin
      step(mk(1, 0, base+t, 0, 0, 0, 0, 0, 0, 0, 1), '0);
      pm[base+t] = m_pop();
    end
    check("fifo_cnt_drained", OW'(dut.cnt), OW'(fifo_m.size()));
    for (int t = 0; t < n; t++) begin
      step(mk(0, 0, base+t, 0, 0, 0, 0, 0, 0, 1, 0), '0);
      check($sformatf("pmem_rd%0d", base+t), bus.out, pm[base+t]);
    end
  endtask

  task automatic run_round(input int mode);
    for (int a = 0; a < 8; a++)
      for (int j = 0; j < PR; j++) begin
        qm[a][j] = (mode == 0) ? 1  : int'($urandom_range(0, 255)) - 128;
        km[a][j] = (mode == 0) ? -1 : int'($urandom_range(0, 255)) - 128;
      end
    for (int a = 0; a < 8; a++) begin
      step(mk(0, a, 0, 0, 0, 0, 1, 0, 0, 0, 0), row_bits(qm[a]));
      step(mk(0, a, 0, 0, 0, 0, 0, 0, 1, 0, 0), row_bits(km[a]));
    end
    for (int a = 0; a < 8; a++) begin
      step(mk(0, a, 0, 0, 0, 1, 0, 0, 0, 0, 0), '0);
      check($sformatf("qmem_rd%0d", a), OW'(dut.qmem_q), OW'(row_bits(qm[a])));
      step(mk(0, a, 0, 0, 0, 0, 0, 1, 0, 0, 0), '0);
      check($sformatf("kmem_rd%0d", a), OW'(dut.kmem_q), OW'(row_bits(km[a])));
    end
    if (mode == 1) begin
      step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), '0);
      step(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), row_bits(qm[1]));
      check("qmem_rdwr_hold", OW'(dut.qmem_q), OW'(row_bits(qm[0])));
    end

    for (int a = 0; a < 8; a++) step(mk(0, a, 0, 0, 1, 0, 0, 1, 0, 0, 0), '0);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), '0);
    idle();
    for (int c = 0; c < COL; c++) kr[c] = km[c];
    check("kcnt_after_load", OW'(dut.kcnt), '0);

    for (int t = 0; t < 8; t++) begin
      step(mk(0, t, 0, 1, 0, 1, 0, 0, 0, 0, 0), '0);
      m_push(dot_row(t));
    end
    idle();
    idle();
    check("fifo_cnt_exec", OW'(dut.cnt), OW'(fifo_m.size()));
    drain_and_read(8, 0);
  endtask

  initial begin
    reset      = 1'b0;
    bus.inst   = '0;
    bus.mem_in = '0;
    for (int c = 0; c < COL; c++)
      for (int k = 0; k < PR; k++) kr[c][k] = 0;
    #1;
    check("reset_out", bus.out, '0);
    check("reset_cnt", OW'(dut.cnt), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_round(0);
    check("all_minus8", pm[0], {COL{20'hFFFF8}});
    run_round(1);
    run_round(1);

    // Overflow: 17 pushes without pop, the last is dropped.
    for (int n = 0; n < 17; n++) begin
      step(mk(0, n % 8, 0, 1, 0, 1, 0, 0, 0, 0, 0), '0);
      m_push(dot_row(n % 8));
    end
    idle();
    idle();
    check("fifo_cnt_full", OW'(dut.cnt), 16);
    drain_and_read(16, 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), '0);
    pm[0] = m_pop();
    check("fifo_cnt_underflow", OW'(dut.cnt), '0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), '0);
    check("pop_empty_head", bus.out, '0);

    // Reset in the middle of an execute burst.
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), '0);
    check("pre_reset_out", bus.out, pm[1]);
    for (int t = 0; t < 3; t++) step(mk(0, t, 0, 1, 0, 1, 0, 0, 0, 0, 0), '0);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_out", bus.out, '0);
    check("midrst_cnt", OW'(dut.cnt), '0);
    check("midrst_kcnt", OW'(dut.kcnt), '0);
    fifo_m.delete();
    for (int c = 0; c < COL; c++)
      for (int k = 0; k < PR; k++) kr[c][k] = 0;
    bus.inst = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    for (int t = 1; t < 16; t++) begin
      step(mk(0, 0, t, 0, 0, 0, 0, 0, 0, 1, 0), '0);
      check($sformatf("pmem_keep%0d", t), bus.out, pm[t]);
    end
    step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), '0);
    m_push(dot_row(0));
    idle();
    idle();
    check("post_rst_cnt", OW'(dut.cnt), OW'(fifo_m.size()));
    drain_and_read(1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
